fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/PC width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, instruction buffer entries; power of two, >= 2.
REQ-004 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port i_reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_redirect  input  1  taken branch/jump from execute (pc_sel).
REQ-007 SHALL have port i_redirect_pc  input  XLEN  redirect target (ALU result).
REQ-008 SHALL have port o_imem_req_vld  output  1  fetch request valid.
REQ-009 SHALL have port o_imem_addr  output  XLEN  fetch address.
REQ-010 SHALL have port i_imem_req_rdy  input  1  memory accepts request.
REQ-011 SHALL have port i_imem_rsp_vld  input  1  instruction word returned.
REQ-012 SHALL have port i_imem_rsp_data  input  32  returned instruction.
REQ-013 SHALL have port o_insn_vld  output  1  instruction available to decode.
REQ-014 SHALL have port o_insn  output  32  instruction at buffer head.
REQ-015 SHALL have port o_insn_pc  output  XLEN  PC of o_insn.
REQ-016 SHALL have port i_insn_rdy  input  1  decode consumes instruction.
REQ-017 SHALL have port o_pc_debug  output  XLEN  current fetch PC.

Function
REQ-018 Fetch PC SHALL advance by 4 (modulo 2^XLEN, wrap from all-ones-minus-3 to 0) on each request handshake (req_vld && req_rdy) only.
REQ-019 o_imem_addr SHALL equal fetch PC; bits [1:0] always 0.
REQ-020 o_imem_req_vld SHALL be 1 iff (outstanding + buffer count) < FIFO_DEPTH and i_redirect = 0 (credit rule; buffer can never overflow).
REQ-021 Memory responses SHALL be in order, one per accepted request, latency >= 1 cycle; each accepted address SHALL be queued in an in-flight PC queue (depth FIFO_DEPTH) for pairing.
REQ-022 A non-discarded response SHALL write {pc, insn} into the instruction buffer; visible on o_insn_vld the following cycle (no bypass).
REQ-023 o_insn_vld SHALL equal buffer-not-empty; entry popped on o_insn_vld && i_insn_rdy.
REQ-024 Response push and decode pop in the same cycle SHALL both occur, count unchanged, including when buffer full.
REQ-025 On i_redirect = 1: fetch PC <= {i_redirect_pc[XLEN-1:2], 2'b00} next edge; instruction buffer and in-flight PC queue flushed; discard counter <= outstanding count (including a response arriving that same cycle, which is dropped).
REQ-026 While discard counter > 0, each response SHALL decrement it and be dropped; o_insn_vld SHALL be 0 the cycle after a redirect.
REQ-027 First request to the redirect target SHALL be presented the cycle after i_redirect, subject to REQ-020.
REQ-028 Pop requested in the redirect cycle SHALL complete (decode owns that instruction); flush applies to remaining entries.
REQ-029 Outstanding counter width SHALL be $clog2(FIFO_DEPTH)+1; SHALL never exceed FIFO_DEPTH.

Reset
REQ-030 While i_reset = 0: fetch PC = RESET_PC, counters and both queues empty, o_imem_req_vld = 0, o_insn_vld = 0, o_insn = 0, o_insn_pc = 0.
REQ-031 Reset asserted mid-transaction SHALL abandon all in-flight requests; responses to them after reset release are not expected from memory and SHALL not be tracked.
REQ-032 First request (address RESET_PC) SHALL be presented in the first cycle after reset deasserts.

Structure
REQ-033 XLEN default, RESET_PC default and a fetch-entry struct {pc, insn} SHALL live in shared package riscv_pkg.
REQ-034 One sub-module, fetch_fifo (parametrised width/depth, push, pop, flush, count, full, empty), SHALL be instantiated twice: in-flight PC queue and instruction buffer.

Verification
REQ-035 Reset release, req_rdy = 1, rsp latency 1, insn_rdy = 1 -> requests at 0x0,0x4,0x8...; o_insn_pc sequence 0x0,0x4,0x8 one per cycle after 3-cycle fill.
REQ-036 insn_rdy = 0, FIFO_DEPTH = 4 -> exactly 4 requests issued, then req_vld = 0; buffer holds PCs 0x0-0xC; raising insn_rdy resumes fetch at 0x10.
REQ-037 Rsp latency 3, redirect to 0x103 with 2 requests outstanding -> both responses dropped, next request address 0x100, next o_insn_pc 0x100.
REQ-038 Fetch PC 0xFFFF_FFFC (XLEN 32) handshake -> next address 0x0000_0000.
REQ-039 i_reset pulled low with 3 outstanding, released -> req at RESET_PC next cycle, o_insn_vld = 0 until new response.
REQ-040 Redirect coincident with response and pop -> popped instruction delivered once, response dropped, discard counter correct (no stale insn later).

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-path defaults and the {pc, insn} entry type.
package riscv_pkg;
    localparam int XLEN_DEFAULT = 32;
    localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [31:0]             insn;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular FIFO with synchronous flush; serves as in-flight PC queue and instruction buffer.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [WIDTH-1:0]       i_data,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_rd, r_wr;
    logic [AW:0] r_count;
    logic w_push, w_pop;
    assign o_empty = r_count == '0;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign w_pop   = i_pop && !o_empty;
    // a pop frees the slot a same-cycle push needs, so push+pop works when full
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            r_rd    <= r_rd + AW'(w_pop);
            r_wr    <= r_wr + AW'(w_push);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-based in-order instruction fetch with redirect flush and stale-response discard.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN       = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEFAULT),
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_imem_req_vld,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_req_rdy,
    input  logic            i_imem_rsp_vld,
    input  logic [31:0]     i_imem_rsp_data,
    output logic            o_insn_vld,
    output logic [31:0]     o_insn,
    output logic [XLEN-1:0] o_insn_pc,
    input  logic            i_insn_rdy,
    output logic [XLEN-1:0] o_pc_debug
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [XLEN-1:0] r_pc, w_q_pc;
    logic [CW-1:0] r_discard, w_q_count, w_b_count, w_outstanding;
    logic [CW:0] w_used;
    logic [XLEN+31:0] w_b_head;
    logic w_q_full, w_q_empty, w_b_full, w_b_empty, w_hs, w_rsp, w_take, w_pop;
    // in-flight queue holds only live requests; discarded ones are counted in r_discard
    assign w_outstanding  = w_q_count + r_discard;
    assign w_used         = {1'b0, w_outstanding} + {1'b0, w_b_count};
    assign o_imem_req_vld = i_reset && !i_redirect && !w_q_full && !w_b_full
                            && w_used < (CW+1)'(FIFO_DEPTH);
    assign o_imem_addr    = r_pc;
    assign o_pc_debug     = r_pc;
    assign w_hs           = o_imem_req_vld && i_imem_req_rdy;
    assign w_rsp          = i_imem_rsp_vld && w_outstanding != '0;
    assign w_take         = w_rsp && r_discard == '0 && !i_redirect;
    assign o_insn_vld     = !w_b_empty;
    assign w_pop          = o_insn_vld && i_insn_rdy;
    assign o_insn         = w_b_empty ? '0 : w_b_head[31:0];
    assign o_insn_pc      = w_b_empty ? '0 : w_b_head[XLEN+31:32];
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pc      <= RESET_PC & ~XLEN'(3);
            r_discard <= '0;
        end else begin
            r_pc      <= i_redirect ? (i_redirect_pc & ~XLEN'(3)) : w_hs ? r_pc + XLEN'(4) : r_pc;
            r_discard <= i_redirect ? w_outstanding - CW'(w_rsp)
                                    : r_discard - CW'(w_rsp && r_discard != '0);
        end
    end
    fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_inflight (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_hs),
        .i_pop   (w_take),
        .i_flush (i_redirect),
        .i_data  (r_pc),
        .o_data  (w_q_pc),
        .o_count (w_q_count),
        .o_full  (w_q_full),
        .o_empty (w_q_empty)
    );
    fetch_fifo #(.WIDTH(XLEN + 32), .DEPTH(FIFO_DEPTH)) u_ibuf (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_take && !w_q_empty),
        .i_pop   (w_pop),
        .i_flush (i_redirect),
        .i_data  ({w_q_pc, i_imem_rsp_data}),
        .o_data  (w_b_head),
        .o_count (w_b_count),
        .o_full  (w_b_full),
        .o_empty (w_b_empty)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table, directed corner sequences and a randomized run against a queue-level fetch model.
module tb_fetch_unit;
    import riscv_pkg::*;
    localparam int D = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;

    typedef struct {
        logic        rst, rr, ir, e_rv, e_iv;
        logic [31:0] e_addr, e_ipc;
    } vec_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; bit live; } inf_t;

    logic clk = 1'b0, rst_n = 1'b1, redirect = 1'b0, req_rdy = 1'b0, rsp_vld = 1'b0, insn_rdy = 1'b0;
    logic [31:0] redirect_pc = '0, rsp_data = '0;
    logic req_vld, insn_vld;
    logic [31:0] addr, insn, insn_pc, pc_debug;
    mreq_t mem_q[$];
    inf_t m_inf[$];
    fetch_entry_t m_buf[$];
    logic [31:0] m_pc = RPC;
    int cyc = 0, lat_min = 1, lat_max = 1, total = 0, bad = 0;
    logic s_rv, s_iv;
    logic [31:0] s_addr, s_ipc;
    vec_t tbl[14];

    fetch_unit #(.XLEN(32), .RESET_PC(RPC), .FIFO_DEPTH(D)) dut (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .i_redirect     (redirect),
        .i_redirect_pc  (redirect_pc),
        .o_imem_req_vld (req_vld),
        .o_imem_addr    (addr),
        .i_imem_req_rdy (req_rdy),
        .i_imem_rsp_vld (rsp_vld),
        .i_imem_rsp_data(rsp_data),
        .o_insn_vld     (insn_vld),
        .o_insn         (insn),
        .o_insn_pc      (insn_pc),
        .i_insn_rdy     (insn_rdy),
        .o_pc_debug     (pc_debug)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // one clock: drive at negedge, compare at +1, advance model and memory at posedge
    task automatic step(input logic rd, input logic [31:0] rpc, input logic rr, input logic ir);
        logic m_rv, hs;
        inf_t f;
        int due;
        redirect = rd; redirect_pc = rpc; req_rdy = rr; insn_rdy = ir;
        rsp_vld = mem_q.size() > 0 && mem_q[0].due <= cyc;
        rsp_data = rsp_vld ? hash(mem_q[0].addr) : 32'hDEAD_BEEF;
        #1;
        m_rv = !rd && (m_inf.size() + m_buf.size()) < D;
        s_rv = req_vld; s_addr = addr; s_iv = insn_vld; s_ipc = insn_pc;
        chk("req_vld", 32'(req_vld), 32'(m_rv));
        chk("imem_addr", addr, m_pc);
        chk("pc_debug", pc_debug, m_pc);
        chk("insn_vld", 32'(insn_vld), 32'(m_buf.size() > 0));
        if (m_buf.size() > 0) begin
            chk("insn_pc", insn_pc, m_buf[0].pc);
            chk("insn", insn, m_buf[0].insn);
        end
        hs = req_vld && rr;
        @(posedge clk);
        if (m_buf.size() > 0 && ir) void'(m_buf.pop_front());
        if (rsp_vld) begin
            void'(mem_q.pop_front());
            if (m_inf.size() > 0) begin
                f = m_inf.pop_front();
                if (f.live && !rd) m_buf.push_back('{pc: f.pc, insn: hash(f.pc)});
            end
        end
        if (hs) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (mem_q.size() > 0 && mem_q[$].due > due) due = mem_q[$].due;
            mem_q.push_back('{addr: addr, due: due});
        end
        if (rd) begin
            foreach (m_inf[i]) m_inf[i].live = 1'b0;
            m_buf.delete();
            m_pc = rpc & ~32'h3;
        end else if (m_rv && rr) begin
            m_inf.push_back('{pc: m_pc, live: 1'b1});
            m_pc = m_pc + 32'd4;
        end
        cyc++;
        @(negedge clk);
    endtask

    // asynchronous assert at negedge; memory abandons everything in flight
    task automatic do_reset();
        rst_n = 1'b0; redirect = 1'b0; req_rdy = 1'b0; rsp_vld = 1'b0; insn_rdy = 1'b0;
        #1;
        chk("rst_req_vld", 32'(req_vld), 32'h0);
        chk("rst_insn_vld", 32'(insn_vld), 32'h0);
        chk("rst_insn", insn, 32'h0);
        chk("rst_insn_pc", insn_pc, 32'h0);
        chk("rst_pc", pc_debug, RPC);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mem_q.delete(); m_inf.delete(); m_buf.delete(); m_pc = RPC;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [31:0] pend_pc;
        //        rst rr ir rv iv addr          ipc
        tbl[0]  = '{1, 1, 1, 1, 0, 32'h00, 32'h0};
        tbl[1]  = '{0, 1, 1, 1, 0, 32'h04, 32'h0};
        tbl[2]  = '{0, 1, 1, 1, 1, 32'h08, 32'h0};
        tbl[3]  = '{0, 1, 1, 1, 1, 32'h0C, 32'h4};
        tbl[4]  = '{0, 1, 1, 1, 1, 32'h10, 32'h8};
        tbl[5]  = '{1, 1, 0, 1, 0, 32'h00, 32'h0};
        tbl[6]  = '{0, 1, 0, 1, 0, 32'h04, 32'h0};
        tbl[7]  = '{0, 1, 0, 1, 1, 32'h08, 32'h0};
        tbl[8]  = '{0, 1, 0, 1, 1, 32'h0C, 32'h0};
        tbl[9]  = '{0, 1, 0, 0, 1, 32'h10, 32'h0};
        tbl[10] = '{0, 1, 0, 0, 1, 32'h10, 32'h0};
        tbl[11] = '{0, 1, 1, 0, 1, 32'h10, 32'h0};
        tbl[12] = '{0, 1, 1, 1, 1, 32'h10, 32'h4};
        tbl[13] = '{0, 1, 1, 1, 1, 32'h14, 32'h8};
        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].rst) do_reset();
            step(1'b0, 32'h0, tbl[i].rr, tbl[i].ir);
            chk($sformatf("tbl%0d_rv", i), 32'(s_rv), 32'(tbl[i].e_rv));
            chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_iv", i), 32'(s_iv), 32'(tbl[i].e_iv));
            if (tbl[i].e_iv) chk($sformatf("tbl%0d_ipc", i), s_ipc, tbl[i].e_ipc);
        end

        // PC wrap at the top of the address space
        do_reset();
        step(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("wrap_top_addr", s_addr, 32'hFFFF_FFFC);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("wrap_zero_addr", s_addr, 32'h0);

        // redirect with two requests outstanding, latency 3
        do_reset();
        lat_min = 3; lat_max = 3;
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h103, 1'b0, 1'b0);
        chk("redir_vld_after", 32'(insn_vld), 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("redir_req_vld", 32'(s_rv), 32'h1);
        chk("redir_req_addr", s_addr, 32'h100);
        for (k = 0; k < 20 && !insn_vld; k++) step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("redir_first_vld", 32'(insn_vld), 32'h1);
        chk("redir_first_pc", insn_pc, 32'h100);

        // reset mid-transaction with three requests outstanding
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        do_reset();
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("rerst_req_vld", 32'(s_rv), 32'h1);
        chk("rerst_req_addr", s_addr, RPC);
        chk("rerst_insn_vld", 32'(s_iv), 32'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

        // redirect coincident with a response and a pop
        do_reset();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
        pend_pc = 32'h10;
        step(1'b1, 32'h200, 1'b1, 1'b1);
        chk("coinc_pop_vld", 32'(s_iv), 32'h1);
        chk("coinc_pop_pc", s_ipc, pend_pc);
        chk("coinc_vld_after", 32'(insn_vld), 32'h0);
        for (k = 0; k < 20 && !insn_vld; k++) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("coinc_next_vld", 32'(insn_vld), 32'h1);
        chk("coinc_next_pc", insn_pc, 32'h200);

        // randomized traffic
        do_reset();
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(199) == 0) do_reset();
            step($urandom_range(15) == 0, $urandom, $urandom_range(3) != 0, $urandom_range(3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
